gray_counter_n: RTL
===================

Name: gray_counter_n

Overview:
Parametrised N-bit Gray-code counter. It is the general successor to the fixed 3-bit Gray counter. It adds:
- configurable width
- up/down direction
- synchronous parallel load
- sticky overflow/underflow flags with software clear
- a one-cycle wrap pulse
- a binary-equivalent output

It sits in the datapath wherever a glitch-free, single-bit-change sequence index is needed, e.g. FIFO pointers and position encoders.

Parameters:
WIDTH, 3, counter width in bits (legal range 2..16).
INIT_GRAY, 0, Gray value loaded on reset. Must be a legal WIDTH-bit value.

Ports:
Clk  input  1  rising-edge clock
Reset  input  1  asynchronous, active-high reset
En  input  1  count enable, one step per cycle while high
Up  input  1  direction: 1 = increment, 0 = decrement (Gray sequence order)
Load  input  1  synchronous load strobe
LoadVal  input  WIDTH  Gray-coded value to load
ClrFlags  input  1  synchronous clear of Overflow and Underflow
Output  output  WIDTH  current Gray code (registered)
Binary  output  WIDTH  binary equivalent of Output (registered, same cycle)
Overflow  output  1  sticky: set on up-wrap from max to 0
Underflow  output  1  sticky: set on down-wrap from 0 to max
Wrap  output  1  registered one-cycle pulse on any wrap

Behaviour:
- State is held as a binary register b[WIDTH-1:0].
  - Output = b ^ (b >> 1), registered. Output and Binary update on the same edge.
  - Incoming LoadVal is converted Gray to binary: b[i] = XOR of LoadVal[WIDTH-1:i].
- Reset asserted (async, takes effect immediately, no clock needed):
  - b = gray2bin(INIT_GRAY), so Output = INIT_GRAY and Binary = gray2bin(INIT_GRAY).
  - Overflow = 0, Underflow = 0, Wrap = 0.
  - Reset mid-count discards all in-flight state.
  - Counting resumes on the first rising edge after Reset deasserts, if En = 1.
- Priority on each rising edge (Reset low): Load > En.
  - Load = 1: b = gray2bin(LoadVal). Count is suppressed that cycle. Wrap = 0. Flags are not set by a load.
  - Load = 0, En = 1, Up = 1:
    - b == 2^WIDTH-1: b = 0, Overflow = 1, Wrap = 1.
    - Otherwise b = b + 1, Wrap = 0.
  - Load = 0, En = 1, Up = 0:
    - b == 0: b = 2^WIDTH-1, Underflow = 1, Wrap = 1.
    - Otherwise b = b - 1, Wrap = 0.
  - En = 0 and Load = 0: hold b and the flags. Wrap = 0.
- Latency: one clock from En/Load sampling to updated Output/Binary/Wrap.
- ClrFlags = 1 clears both Overflow and Underflow on that edge.
  - If a wrap occurs on the same edge, the flag for that wrap direction is set (set wins). The other flag clears.
  - Wrap is never affected by ClrFlags.
- Both flags may be 1 simultaneously after wraps in both directions without an intervening clear.
- Direction may change on any cycle with no dead cycle. Consecutive Output values always differ in exactly one bit, except across Load.
- Width rule: all arithmetic is modulo 2^WIDTH, with no carry-out beyond the flags.
- WIDTH = 3, INIT_GRAY = 0 reproduces the legacy up-counting sequence and Overflow behaviour exactly, with Up tied to 1 and Load and ClrFlags tied to 0. The one exception: this block's reset is asynchronous.

Test Plan:
1. WIDTH=3, reset, then En=1, Up=1 for 9 cycles:
   - Output = 000,001,011,010,110,111,101,100,000.
   - Overflow rises with the final 000 and stays 1.
   - Wrap is high for exactly that one cycle.
   - Binary tracks 0..7,0.
2. WIDTH=3, reset, then En=1, Up=0 for 2 cycles:
   - Output = 100 then 101. Binary = 7 then 6.
   - Underflow = 1 from the first step. Wrap pulses on the first step only.
3. WIDTH=4, Load=1 with LoadVal=4'b1100 (binary 8) and En=1 in the same cycle:
   - Output = 1100, Binary = 1000, no count.
   - Next cycle with En=1, Up=1: Output = 1101, Binary = 1001.
4. WIDTH=3 with Overflow=1:
   - At b=7, apply ClrFlags=1 together with an up-wrap: Overflow remains 1.
   - Next cycle, ClrFlags=1, En=0: Overflow = 0 and Underflow = 0.
5. Assert Reset asynchronously mid-cycle while counting at Output=110:
   - Output = 000, Binary = 000 and all flags = 0 before the next Clk edge.
   - Hold Reset across 2 edges: Output stays 000.
6. WIDTH=8, INIT_GRAY=8'h80, up-count 256 cycles:
   - Every transition changes exactly one bit.
   - Return to 8'h80 after exactly 256 steps.
   - Overflow is set at the 255->0 step only.

Source files
------------

// File: rtl/gray_counter_n.sv
// gray_counter_n: parametrised up/down Gray-code counter with parallel load,
// sticky overflow/underflow flags, a one-cycle wrap pulse and a binary mirror.
// The count is held in binary. The Gray code is derived from the next binary
// value and registered, so Output and Binary change on the same edge.
module gray_counter_n #(
   parameter int unsigned      WIDTH     = 3,
   parameter logic [WIDTH-1:0] INIT_GRAY = '0
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             En,
   input  logic             Up,
   input  logic             Load,
   input  logic [WIDTH-1:0] LoadVal,
   input  logic             ClrFlags,
   output logic [WIDTH-1:0] Output,
   output logic [WIDTH-1:0] Binary,
   output logic             Overflow,
   output logic             Underflow,
   output logic             Wrap
);

   // Gray to binary: bit i is the XOR of all bits at i and above (prefix XOR by doubling shifts)
   function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
      logic [WIDTH-1:0] b;
      b = g;
      for (int unsigned s = 1; s < WIDTH; s = s * 2) begin
         b = b ^ (b >> s);
      end
      return b;
   endfunction

   localparam logic [WIDTH-1:0] INIT_BIN = gray2bin(INIT_GRAY);
   localparam logic [WIDTH-1:0] MAX_BIN  = '1;

   logic [WIDTH-1:0] bin_next;
   logic [WIDTH-1:0] gray_next;
   logic             wrap_next;
   logic             ovf_set;
   logic             unf_set;
   logic             ovf_next;
   logic             unf_next;

   // Next count: load beats count enable; wraps raise the matching flag request
   always_comb begin
      bin_next  = Binary;
      wrap_next = 1'b0;
      ovf_set   = 1'b0;
      unf_set   = 1'b0;
      if (Load) begin
         bin_next = gray2bin(LoadVal);
      end else if (En) begin
         if (Up) begin
            if (Binary == MAX_BIN) begin
               bin_next  = '0;
               wrap_next = 1'b1;
               ovf_set   = 1'b1;
            end else begin
               bin_next = Binary + WIDTH'(1);
            end
         end else begin
            if (Binary == '0) begin
               bin_next  = MAX_BIN;
               wrap_next = 1'b1;
               unf_set   = 1'b1;
            end else begin
               bin_next = Binary - WIDTH'(1);
            end
         end
      end
      gray_next = bin_next ^ (bin_next >> 1);
      // a wrap on the same edge as a clear keeps its own flag set
      ovf_next  = ovf_set | (Overflow  & ~ClrFlags);
      unf_next  = unf_set | (Underflow & ~ClrFlags);
   end

   // Count, flag and wrap registers; reset restores the initial Gray value
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         Binary    <= INIT_BIN;
         Output    <= INIT_GRAY;
         Overflow  <= 1'b0;
         Underflow <= 1'b0;
         Wrap      <= 1'b0;
      end else begin
         Binary    <= bin_next;
         Output    <= gray_next;
         Overflow  <= ovf_next;
         Underflow <= unf_next;
         Wrap      <= wrap_next;
      end
   end

endmodule
